dsp_share_arbiter: RTL and testbench

DSP_SHARE_ARBITER -- requirements
Module: dsp_share_arbiter

---
 rtl/dsp_share_arbiter.sv | 145 ++++++++++++++
 tb/tb_dsp_share_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_share_arbiter.sv
// dsp_share_arbiter: shares one (A+/-D)*B+C pipeline among NREQ requesters.
// Picks one request per cycle, registers its operands onto dsp_*, tags the
// op with its owner and returns the pipeline result on rsp_* LAT+1 cycles
// after acceptance.
// Ports: clk, rst_n (async, active low), en (grant enable),
//   req_valid/req_ready/req_subadd/req_a/req_d/req_b/req_c (per requester),
//   dsp_subadd/dsp_ain/dsp_din/dsp_bin/dsp_cin (to pipeline), dsp_pout (from it),
//   rsp_valid/rsp_id/rsp_data (result), issue_cnt (accepted op count).
// Macro DSP_ARB_RR_EN: round-robin arbitration; otherwise fixed priority.

module dsp_share_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 16,
    parameter int BW   = 18,
    parameter int CW   = 32,
    parameter int PW   = 48,
    parameter int LAT  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0]           req_subadd,
    input  logic [NREQ*AW-1:0]        req_a,
    input  logic [NREQ*AW-1:0]        req_d,
    input  logic [NREQ*BW-1:0]        req_b,
    input  logic [NREQ*CW-1:0]        req_c,
    output logic                      dsp_subadd,
    output logic [AW-1:0]             dsp_ain,
    output logic [AW-1:0]             dsp_din,
    output logic [BW-1:0]             dsp_bin,
    output logic [CW-1:0]             dsp_cin,
    input  logic [PW-1:0]             dsp_pout,
    output logic                      rsp_valid,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [PW-1:0]             rsp_data,
    output logic [31:0]               issue_cnt
);

    localparam int IW = $clog2(NREQ);

    logic          win_any;
    logic [IW-1:0] win_id;

`ifdef DSP_ARB_RR_EN
    logic [IW-1:0] ptr;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    // Search starts at the pointer and wraps; first valid requester wins.
    always_comb begin
        win_any = 1'b0;
        win_id  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_any && en && req_valid[wrap_add(ptr, k)]) begin
                win_any = 1'b1;
                win_id  = wrap_add(ptr, k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (win_any)
            ptr <= wrap_add(win_id, 1);
    end
`else
    // Scan from the top so the lowest valid index is the last write.
    always_comb begin
        win_any = 1'b0;
        win_id  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (en && req_valid[k]) begin
                win_any = 1'b1;
                win_id  = IW'(k);
            end
        end
    end
`endif

    always_comb begin
        req_ready = '0;
        if (win_any)
            req_ready[win_id] = 1'b1;
    end

    // Operand registers: winner's operands, or zero when nothing is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsp_subadd <= 1'b0;
            dsp_ain    <= '0;
            dsp_din    <= '0;
            dsp_bin    <= '0;
            dsp_cin    <= '0;
        end else if (win_any) begin
            dsp_subadd <= req_subadd[win_id];
            dsp_ain    <= req_a[int'(win_id)*AW +: AW];
            dsp_din    <= req_d[int'(win_id)*AW +: AW];
            dsp_bin    <= req_b[int'(win_id)*BW +: BW];
            dsp_cin    <= req_c[int'(win_id)*CW +: CW];
        end else begin
            dsp_subadd <= 1'b0;
            dsp_ain    <= '0;
            dsp_din    <= '0;
            dsp_bin    <= '0;
            dsp_cin    <= '0;
        end
    end

    // Tag stage 0 lines up with dsp_*, stage LAT with dsp_pout.
    logic [LAT:0]  tag_v;
    logic [IW-1:0] tag_id [LAT+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
            for (int k = 0; k <= LAT; k++)
                tag_id[k] <= '0;
        end else begin
            tag_v     <= {tag_v[LAT-1:0], win_any};
            tag_id[0] <= win_any ? win_id : '0;
            for (int k = 1; k <= LAT; k++)
                tag_id[k] <= tag_id[k-1];
        end
    end

    assign rsp_valid = tag_v[LAT];
    assign rsp_id    = tag_id[LAT];
    assign rsp_data  = dsp_pout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            issue_cnt <= '0;
        else if (win_any)
            issue_cnt <= issue_cnt + 32'd1;
    end

endmodule

// File: tb/tb_dsp_share_arbiter.sv
// tb_dsp_share_arbiter: randomized + directed bench for dsp_share_arbiter.
// Models the external DSP pipeline and checks against a queue-based reference.

module tb_dsp_share_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 16;
    localparam int BW   = 18;
    localparam int CW   = 32;
    localparam int PW   = 48;
    localparam int LAT  = 4;
    localparam int IW   = $clog2(NREQ);

    logic                clk;
    logic                rst_n;
    logic                en;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     req_subadd;
    logic [NREQ*AW-1:0]  req_a;
    logic [NREQ*AW-1:0]  req_d;
    logic [NREQ*BW-1:0]  req_b;
    logic [NREQ*CW-1:0]  req_c;
    logic                dsp_subadd;
    logic [AW-1:0]       dsp_ain;
    logic [AW-1:0]       dsp_din;
    logic [BW-1:0]       dsp_bin;
    logic [CW-1:0]       dsp_cin;
    logic [PW-1:0]       dsp_pout;
    logic                rsp_valid;
    logic [IW-1:0]       rsp_id;
    logic [PW-1:0]       rsp_data;
    logic [31:0]         issue_cnt;

    dsp_share_arbiter #(
        .NREQ(NREQ), .AW(AW), .BW(BW), .CW(CW), .PW(PW), .LAT(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req_valid(req_valid), .req_ready(req_ready), .req_subadd(req_subadd),
        .req_a(req_a), .req_d(req_d), .req_b(req_b), .req_c(req_c),
        .dsp_subadd(dsp_subadd), .dsp_ain(dsp_ain), .dsp_din(dsp_din),
        .dsp_bin(dsp_bin), .dsp_cin(dsp_cin), .dsp_pout(dsp_pout),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .issue_cnt(issue_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External shared pipeline: LAT register stages after the operand regs.
    longint pipe [LAT];
    initial for (int k = 0; k < LAT; k++) pipe[k] = 0;

    always @(posedge clk) begin
        longint pre;
        pre = dsp_subadd ? longint'($signed(dsp_ain)) - longint'($signed(dsp_din))
                         : longint'($signed(dsp_ain)) + longint'($signed(dsp_din));
        for (int k = LAT - 1; k > 0; k--) pipe[k] <= pipe[k-1];
        pipe[0] <= pre * longint'($signed(dsp_bin)) + longint'($signed(dsp_cin));
    end

    assign dsp_pout = PW'(pipe[LAT-1]);

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int     due;
        int     id;
        longint data;
    } rsp_t;

    rsp_t        q[$];
    int          cyc;
    int          m_ptr;
    longint      m_cnt;
    bit          e_sub;
    longint      e_a, e_d, e_b, e_c;
    int          last_w;

    function automatic longint opa(input int i);
        return longint'($signed(req_a[i*AW +: AW]));
    endfunction
    function automatic longint opd(input int i);
        return longint'($signed(req_d[i*AW +: AW]));
    endfunction
    function automatic longint opb(input int i);
        return longint'($signed(req_b[i*BW +: BW]));
    endfunction
    function automatic longint opc(input int i);
        return longint'($signed(req_c[i*CW +: CW]));
    endfunction

    function automatic int model_pick();
        if (!en) return -1;
`ifdef DSP_ARB_RR_EN
        for (int k = 0; k < NREQ; k++)
            if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
`else
        for (int k = 0; k < NREQ; k++)
            if (req_valid[k]) return k;
`endif
        return -1;
    endfunction

    task automatic set_op(input int i, input bit sub, input longint a,
                          input longint d, input longint b, input longint c);
        req_subadd[i]      = sub;
        req_a[i*AW +: AW]  = AW'(a);
        req_d[i*AW +: AW]  = AW'(d);
        req_b[i*BW +: BW]  = BW'(b);
        req_c[i*CW +: CW]  = CW'(c);
    endtask

    // One cycle: called at a falling edge with inputs already driven.
    task automatic step();
        int w;
        logic [NREQ-1:0] er;
        rsp_t r;
        longint pre;
        #1;
        w = model_pick();
        last_w = w;
        er = '0;
        if (w >= 0) er[w] = 1'b1;
        chk("req_ready", longint'(req_ready), longint'(er));
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("rsp_valid", longint'(rsp_valid), 1);
            chk("rsp_id", longint'(rsp_id), q[0].id);
            chk("rsp_data", longint'($signed(rsp_data)), q[0].data);
            void'(q.pop_front());
        end else begin
            chk("rsp_valid", longint'(rsp_valid), 0);
        end
        chk("dsp_subadd", longint'(dsp_subadd), longint'(e_sub));
        chk("dsp_ain", longint'($signed(dsp_ain)), e_a);
        chk("dsp_din", longint'($signed(dsp_din)), e_d);
        chk("dsp_bin", longint'($signed(dsp_bin)), e_b);
        chk("dsp_cin", longint'($signed(dsp_cin)), e_c);
        chk("issue_cnt", longint'(issue_cnt), m_cnt);
        if (w >= 0) begin
            e_sub = req_subadd[w];
            e_a = opa(w); e_d = opd(w); e_b = opb(w); e_c = opc(w);
            pre = e_sub ? e_a - e_d : e_a + e_d;
            r.due  = cyc + LAT + 1;
            r.id   = w;
            r.data = pre * e_b + e_c;
            q.push_back(r);
            m_cnt = (m_cnt + 1) % 64'h1_0000_0000;
            m_ptr = (w + 1) % NREQ;
        end else begin
            e_sub = 1'b0; e_a = 0; e_d = 0; e_b = 0; e_c = 0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_dsp", longint'({dsp_subadd, dsp_ain, dsp_din}) +
                       longint'(dsp_bin) + longint'(dsp_cin), 0);
        chk("rst_rsp_valid", longint'(rsp_valid), 0);
        chk("rst_rsp_id", longint'(rsp_id), 0);
        chk("rst_issue_cnt", longint'(issue_cnt), 0);
        q.delete();
        m_ptr = 0; m_cnt = 0;
        e_sub = 1'b0; e_a = 0; e_d = 0; e_b = 0; e_c = 0;
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        repeat (n) step();
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++)
            set_op(i, 1'($urandom), longint'($urandom), longint'($urandom),
                   longint'($urandom), longint'($urandom));
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0;
        req_valid = '0; req_subadd = '0;
        req_a = '0; req_d = '0; req_b = '0; req_c = '0;
        cyc = 0; m_ptr = 0; m_cnt = 0; last_w = -1;
        e_sub = 1'b0; e_a = 0; e_d = 0; e_b = 0; e_c = 0;
        @(negedge clk);
        do_reset();
        en = 1'b1;

        // Single op from requester 1, add then subtract.
        set_op(1, 1'b0, 100, 20, 3, 7);
        req_valid = 4'b0010;
        step();
        chk("single_grant", last_w, 1);
        idle(LAT + 2);
        set_op(1, 1'b1, 100, 20, 3, 7);
        req_valid = 4'b0010;
        step();
        idle(LAT + 2);

        // All requesters held valid for 8 cycles from a fresh pointer.
        do_reset();
        rand_ops();
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
`ifdef DSP_ARB_RR_EN
            chk("grant_seq", last_w, k % NREQ);
`else
            chk("grant_seq", last_w, 0);
`endif
        end
        idle(LAT + 2);
        chk("issue_cnt8", longint'(issue_cnt), 8);

        // Grant enable dropped during streaming.
        req_valid = 4'b1111;
        rand_ops();
        repeat (3) step();
        en = 1'b0;
        repeat (3) step();
        en = 1'b1;
        repeat (2) step();
        idle(LAT + 2);

        // Reset with three ops in flight: none of them may respond.
        rand_ops();
        req_valid = 4'b0101;
        repeat (3) step();
        idle(2);
        do_reset();
        idle(LAT + 4);

        // Extreme operands; preadd must not wrap.
        set_op(2, 1'b1, -32768, 32767, -131072, 0);
        req_valid = 4'b0100;
        step();
        idle(LAT + 2);
        chk("boundary_model", q.size(), 0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            rand_ops();
            req_valid = NREQ'($urandom);
            en = ($urandom % 8) != 0;
            step();
        end
        en = 1'b1;
        idle(LAT + 3);
        chk("drain", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
